regfile_writer: RTL

Write-back queue that owns the register file's single write port (`we3`/`ad3`/`wd3`). It accepts results from the ALU path and the load path over valid/ready handshakes, orders them in a small FIFO, and retires one entry per cycle into the register file. It also offers a forwarding lookup so decode sees values that are queued but not yet written. It sits between the execute/memory stages and the 32×32 register file.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_writer_fwd_search.sv | 31 +++
 rtl/regfile_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, write-back entry type and x0 constant for the register-file writer
package regfile_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    // Register x0 is hard-wired to zero; writes to it are dropped.
    localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] rd;
        logic [DEFAULT_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_fwd_search.sv
// rtl/regfile_writer_fwd_search.sv - youngest-match priority search over pending register writes
module wb_fwd_search
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ENTRIES       = 5
) (
    input  logic [ENTRIES-1:0]               valid,
    input  logic [ENTRIES*ADDRESS_WIDTH-1:0] rd,
    input  logic [ENTRIES*DATA_WIDTH-1:0]    data,
    input  logic [ADDRESS_WIDTH-1:0]         q_ad,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            hit_data
);

    // Entries are ordered oldest (index 0) to youngest; a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        if (q_ad != ADDRESS_WIDTH'(REG_ZERO)) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid[i] && (rd[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == q_ad)) begin
                    hit      = 1'b1;
                    hit_data = data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - write-back queue owning the register-file write port; forwarding under REGFILE_WRITER_FWD_EN
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]   mem_rd,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    output logic                       we3,
    output logic [ADDRESS_WIDTH-1:0]   ad3,
    output logic [DATA_WIDTH-1:0]      wd3,
    input  logic [ADDRESS_WIDTH-1:0]   q_ad1,
    input  logic [ADDRESS_WIDTH-1:0]   q_ad2,
    output logic                       fwd1_hit,
    output logic                       fwd2_hit,
    output logic [DATA_WIDTH-1:0]      fwd1_data,
    output logic [DATA_WIDTH-1:0]      fwd2_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         mem_slot;
    logic [CNT_W-1:0]         free;
    logic [CNT_W-1:0]         count_next;
    logic                     pop;
    logic                     alu_req;
    logic                     alu_push;
    logic                     mem_push;

    // The head leaves during the same edge, so its slot already counts as free for incoming results.
    assign pop       = (count != '0);
    assign free      = CNT_W'(DEPTH) - count + CNT_W'(pop);
    assign alu_req   = alu_valid && (alu_rd != ADDRESS_WIDTH'(REG_ZERO));
    assign alu_ready = (free >= CNT_W'(1));
    assign mem_ready = (free >= (CNT_W'(1) + CNT_W'(alu_req)));

    // x0 results complete the handshake but never occupy a slot.
    assign alu_push   = alu_req && alu_ready;
    assign mem_push   = mem_valid && mem_ready && (mem_rd != ADDRESS_WIDTH'(REG_ZERO));
    assign mem_slot   = wr_ptr + PTR_W'(alu_push);
    assign count_next = count + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);

    // Queue storage: ALU result takes the tail slot, a same-cycle load result the one after it.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            rd_q[wr_ptr]   <= alu_rd;
            data_q[wr_ptr] <= alu_data;
        end
        if (mem_push) begin
            rd_q[mem_slot]   <= mem_rd;
            data_q[mem_slot] <= mem_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wr_ptr <= wr_ptr + PTR_W'(alu_push) + PTR_W'(mem_push);
            count  <= count_next;
        end
    end

    // Register-file write port: retire the head each cycle, address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3 <= 1'b0;
            ad3 <= '0;
            wd3 <= '0;
        end else if (pop) begin
            we3 <= 1'b1;
            ad3 <= rd_q[rd_ptr];
            wd3 <= data_q[rd_ptr];
        end else begin
            we3 <= 1'b0;
        end
    end

`ifdef REGFILE_WRITER_FWD_EN
    localparam int ENTRIES = DEPTH + 1;

    logic [ENTRIES-1:0]               srch_valid;
    logic [ENTRIES*ADDRESS_WIDTH-1:0] srch_rd;
    logic [ENTRIES*DATA_WIDTH-1:0]    srch_data;

    // Flatten pending writes oldest-first: output register, then queue from head to tail.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot                       = rd_ptr;
        srch_valid                 = '0;
        srch_rd                    = '0;
        srch_data                  = '0;
        srch_valid[0]              = we3;
        srch_rd[0 +: ADDRESS_WIDTH] = ad3;
        srch_data[0 +: DATA_WIDTH] = wd3;
        for (int i = 0; i < DEPTH; i++) begin
            slot                                     = rd_ptr + PTR_W'(i);
            srch_valid[i+1]                          = (CNT_W'(i) < count);
            srch_rd[(i+1)*ADDRESS_WIDTH +: ADDRESS_WIDTH] = rd_q[slot];
            srch_data[(i+1)*DATA_WIDTH +: DATA_WIDTH]     = data_q[slot];
        end
    end

    wb_fwd_search #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .ENTRIES       (ENTRIES)
    ) u_fwd1 (
        .valid    (srch_valid),
        .rd       (srch_rd),
        .data     (srch_data),
        .q_ad     (q_ad1),
        .hit      (fwd1_hit),
        .hit_data (fwd1_data)
    );

    wb_fwd_search #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .ENTRIES       (ENTRIES)
    ) u_fwd2 (
        .valid    (srch_valid),
        .rd       (srch_rd),
        .data     (srch_data),
        .q_ad     (q_ad2),
        .hit      (fwd2_hit),
        .hit_data (fwd2_data)
    );
`else
    // Without forwarding, decode stalls on pending writes and the lookup ports are ignored.
    logic unused_lookup;
    assign unused_lookup = ^{q_ad1, q_ad2};
    assign fwd1_hit      = 1'b0;
    assign fwd2_hit      = 1'b0;
    assign fwd1_data     = '0;
    assign fwd2_data     = '0;
`endif

endmodule
